// File: rtl/maxpool_unit_if.sv
// rtl/maxpool_unit_if.sv - pixel-in / pooled-out stream handshake bundle
interface maxpool_unit_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/maxpool_unit.sv
// rtl/maxpool_unit.sv - streaming 2x2 stride-2 pooling with a half-width row buffer
// Build option MAXPOOL_AVG_EN selects floor-average pooling instead of signed max.
module maxpool_unit #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 6,
  parameter int IN_H   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  output logic          o_done,
  maxpool_unit_if.slave s
);
  localparam int CW = (IN_W > 2) ? $clog2(IN_W) : 2;
  localparam int RW = $clog2(IN_H);
`ifdef MAXPOOL_AVG_EN
  localparam int HW = DATA_W + 2;
  localparam int BW = DATA_W + 1;
`else
  localparam int HW = DATA_W;
  localparam int BW = DATA_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   r_state, w_next_state;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [HW-1:0]     r_hold;
  logic signed [BW-1:0]     r_rowbuf [IN_W/2];
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_out_valid;
  logic                     r_out_last;

  logic                     w_in_ready, w_in_hs, w_out_hs;
  logic                     w_col_last, w_row_last;
  logic [CW-2:0]            w_idx;
  logic signed [DATA_W-1:0] w_px_raw;
  logic signed [HW-1:0]     w_px, w_rb, w_lhs, w_comb;
  logic signed [DATA_W-1:0] w_result;

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign s.out_last  = r_out_last;

  assign w_in_hs    = s.in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && s.out_ready;
  assign w_col_last = (r_col == CW'(IN_W - 1));
  assign w_row_last = (r_row == RW'(IN_H - 1));

  // Odd-row/even-col merges with the stored pair; every other slot combines with hold.
  always_comb begin
    w_idx    = r_col[CW-1:1];
    w_px_raw = s.in_data;
    w_px     = HW'(w_px_raw);
    w_rb     = HW'(r_rowbuf[w_idx]);
    w_lhs    = (r_row[0] && !r_col[0]) ? w_rb : r_hold;
`ifdef MAXPOOL_AVG_EN
    w_comb   = w_lhs + w_px;
    w_result = DATA_W'(w_comb >>> 2);
`else
    w_comb   = (w_lhs > w_px) ? w_lhs : w_px;
    w_result = w_comb;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (i_start)
      w_next_state = S_RUN;
    else if (r_state == S_RUN && w_out_hs && r_out_last)
      w_next_state = S_DONE;
  end

  always_comb begin
    w_in_ready = (r_state == S_RUN) && (!r_out_valid || s.out_ready);
    o_done     = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < IN_W/2; i++) r_rowbuf[i] <= '0;
    end else if (i_start) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_out_data  <= '0;
      end
      if (w_in_hs) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        case ({r_row[0], r_col[0]})
          2'b00: r_hold <= w_px;
          2'b01: r_rowbuf[w_idx] <= BW'(w_comb);
          2'b10: r_hold <= w_comb;
          default: begin
            r_out_data  <= w_result;
            r_out_valid <= 1'b1;
            r_out_last  <= w_col_last && w_row_last;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_maxpool_unit.sv
// tb/tb_maxpool_unit.sv - directed self-checking bench for maxpool_unit (6x6 -> 3x3)
module tb_maxpool_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic o_done;

  maxpool_unit_if #(.DATA_W(32)) bus ();

  maxpool_unit #(.DATA_W(32), .IN_W(6), .IN_H(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .o_done  (o_done),
    .s       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int px [36];
  int got [$];
  bit gotlast [$];
  int expv [9];
`ifdef MAXPOOL_AVG_EN
  int t1 [9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
  int signed_exp = -6;
  int win0_exp = -1;
  int win1_exp = 4;
`else
  int t1 [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
  int signed_exp = -3;
  int win0_exp = 3;
  int win1_exp = 5;
`endif

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pool_ref(input int a, input int b, input int c, input int d);
`ifdef MAXPOOL_AVG_EN
    return (a + b + c + d) >>> 2;
`else
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  task automatic build_exp();
    for (int wr = 0; wr < 3; wr++)
      for (int wc = 0; wc < 3; wc++) begin
        int b;
        b = wr * 12 + wc * 2;
        expv[wr*3+wc] = pool_ref(px[b], px[b+1], px[b+6], px[b+7]);
      end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, got.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s_val%0d", tag, i), got[i], expv[i]);
      chk($sformatf("%s_last%0d", tag, i), gotlast[i], (i == 8));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    got.delete();
    gotlast.delete();
  endtask

  // rdy_mode: 0 = out_ready high, 1 = pattern 1,0,0,1, 2 = out_ready low
  task automatic feed(input int npx, input int nexp, input int rdy_mode);
    int idx = 0;
    int cyc = 0;
    bit stall_prev = 0;
    logic [31:0] prev_d = '0;
    logic prev_l = 1'b0;
    while ((idx < npx || got.size() < nexp) && cyc < 2000) begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.out_ready = 1'b0;
      endcase
      bus.in_valid = (idx < npx);
      bus.in_data  = (idx < npx) ? px[idx] : 0;
      #1;
      if (stall_prev) begin
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_data", bus.out_data, prev_d);
        chk("bp_hold_last", bus.out_last, prev_l);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      if (stall_prev) begin
        chk("bp_in_ready", bus.in_ready, 0);
        prev_d = bus.out_data;
        prev_l = bus.out_last;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(int'($signed(bus.out_data)));
        gotlast.push_back(bus.out_last);
      end
      cyc++;
    end
    chk("feed_no_timeout", (cyc < 2000), 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_done", o_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;

    // ramp frame, free-flowing output
    for (int k = 0; k < 36; k++) px[k] = k;
    for (int i = 0; i < 9; i++) expv[i] = t1[i];
    pulse_start();
    feed(36, 9, 0);
    chk("done_not_yet", o_done, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("done_rise", o_done, 1);
    chk("done_in_ready", bus.in_ready, 0);
    check_frame("ramp");

    // same frame with backpressure
    pulse_start();
    #1;
    chk("start_clears_done", o_done, 0);
    feed(36, 9, 1);
    check_frame("bp");

    // signed compare in the top-left window
    for (int k = 0; k < 36; k++) px[k] = -100;
    px[0] = -5; px[1] = -3; px[6] = -9; px[7] = -4;
    build_exp();
    pulse_start();
    feed(36, 9, 0);
    chk("signed_first", got[0], signed_exp);
    check_frame("signed");

    // rounding windows
    for (int k = 0; k < 36; k++) px[k] = 0;
    px[0] = 1; px[1] = 2; px[6] = 3; px[7] = -7;
    px[2] = 4; px[3] = 4; px[8] = 4; px[9] = 5;
    build_exp();
    pulse_start();
    feed(36, 9, 0);
    chk("win0", got[0], win0_exp);
    chk("win1", got[1], win1_exp);
    check_frame("win");

    // abandon a frame after 20 pixels, then run a fresh one
    for (int k = 0; k < 36; k++) px[k] = 1000 + k;
    pulse_start();
    feed(20, 3, 0);
    pulse_start();
    #1;
    chk("restart_out_valid", bus.out_valid, 0);
    for (int k = 0; k < 36; k++) px[k] = 200 - k;
    build_exp();
    feed(36, 9, 0);
    check_frame("restart");

    // asynchronous reset while a result is held
    for (int k = 0; k < 36; k++) px[k] = k;
    for (int i = 0; i < 9; i++) expv[i] = t1[i];
    pulse_start();
    feed(8, 0, 2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", bus.out_valid, 1);
    chk("pre_rst_in_ready", bus.in_ready, 0);
    chk("pre_rst_out_data", bus.out_data, t1[0]);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_done", o_done, 0);
    chk("arst_out_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    pulse_start();
    feed(36, 9, 0);
    check_frame("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
